// File: rtl/reg_ctrl_pkg.sv
// Shared definitions for the register-transfer controller: opcodes,
// controller states, instruction field positions and default widths.
package reg_ctrl_pkg;

  localparam int W_DEF  = 8;
  localparam int AW_DEF = 2;

  localparam logic [3:0] OP_MOV = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_INC = 4'd6;
  localparam logic [3:0] OP_LDI = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  // Instruction layout: [7:4] opcode, [3:2] source reg, [1:0] destination reg
  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 4;
  localparam int SRC_MSB = 3;
  localparam int SRC_LSB = 2;
  localparam int DST_MSB = 1;
  localparam int DST_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/reg_ctrl_alu.sv
// Combinational ALU for reg_ctrl. a is the source operand, b the destination
// operand. 'writes' is low for opcodes that do not write back (NOP).
// Build option: define REG_CTRL_SHIFT_EN to turn opcodes 8/9 into SHL/SHR;
// otherwise they behave as NOP like 10-15.
module reg_ctrl_alu
  import reg_ctrl_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] imm,
  output logic [W-1:0] res,
  output logic         carry,
  output logic         zero,
  output logic         writes
);

  // Result and carry per opcode; logic, move and load ops leave carry clear
  always_comb begin
    res    = '0;
    carry  = 1'b0;
    writes = 1'b1;
    case (op)
      OP_MOV: res = a;
      OP_ADD: {carry, res} = {1'b0, b} + {1'b0, a};
      // Top bit of the (W+1)-bit difference is set exactly when b < a
      OP_SUB: {carry, res} = {1'b0, b} - {1'b0, a};
      OP_AND: res = b & a;
      OP_OR:  res = b | a;
      OP_NOT: res = ~a;
      OP_INC: {carry, res} = {1'b0, b} + {{W{1'b0}}, 1'b1};
      OP_LDI: res = imm;
`ifdef REG_CTRL_SHIFT_EN
      OP_SHL: begin
        res   = {b[W-2:0], 1'b0};
        carry = b[W-1];
      end
      OP_SHR: begin
        res   = {1'b0, b[W-1:1]};
        carry = b[0];
      end
`endif
      default: writes = 1'b0;
    endcase
    zero = (res == '0);
  end

endmodule

// File: rtl/reg_ctrl.sv
// Register-transfer controller: initiator side of the 4xW register group.
// Accepts one instruction per handshake, reads operands through the group's
// combinational ports, then writes the result back during one WRITE cycle
// (the group commits on the falling edge while we=1).
// Build option: REG_CTRL_SHIFT_EN (handled in reg_ctrl_alu).
module reg_ctrl
  import reg_ctrl_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  input  logic [7:0]    instr,
  input  logic [W-1:0]  imm,
  output logic          instr_ready,
  input  logic [W-1:0]  s,
  input  logic [W-1:0]  d,
  output logic          we,
  output logic [AW-1:0] sr,
  output logic [AW-1:0] dr,
  output logic [W-1:0]  i,
  output logic          done,
  output logic          zero,
  output logic          carry
);

  state_t       state_q, state_d;
  logic [3:0]   ir_op_q;
  logic [1:0]   ir_dst_q;
  logic [W-1:0] imm_q, op_a_q, op_b_q;
  logic [W-1:0] alu_res;
  logic         alu_carry, alu_zero, alu_writes;
  logic         accept;

  assign accept = instr_valid && instr_ready;

  reg_ctrl_alu #(.W(W)) u_alu (
    .op     (ir_op_q),
    .a      (op_a_q),
    .b      (op_b_q),
    .imm    (imm_q),
    .res    (alu_res),
    .carry  (alu_carry),
    .zero   (alu_zero),
    .writes (alu_writes)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: fixed READ->EXEC walk, EXEC skips WRITE for non-writing ops
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_READ;
      ST_READ:  state_d = ST_EXEC;
      ST_EXEC:  state_d = alu_writes ? ST_WRITE : ST_IDLE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake and write strobe, both forced low while reset is asserted so a
  // reset landing in WRITE suppresses that cycle's falling-edge write
  always_comb begin
    instr_ready = (state_q == ST_IDLE) && !rst;
    we          = (state_q == ST_WRITE) && !rst;
  end

  // Instruction capture, operand latch, bus selects, write data, flags, done
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_op_q  <= '0;
      ir_dst_q <= '0;
      imm_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      sr       <= '0;
      dr       <= '0;
      i        <= '0;
      done     <= 1'b0;
      zero     <= 1'b0;
      carry    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            ir_op_q  <= instr[OP_MSB:OP_LSB];
            ir_dst_q <= instr[DST_MSB:DST_LSB];
            imm_q    <= imm;
            // Selects for READ are set up at accept so s/d are valid all cycle
            sr       <= AW'(instr[SRC_MSB:SRC_LSB]);
            dr       <= AW'(instr[DST_MSB:DST_LSB]);
          end
        end
        ST_READ: begin
          op_a_q <= s;
          op_b_q <= d;
        end
        ST_EXEC: begin
          if (alu_writes) begin
            // The group's write select decodes both selects, so sr follows dr
            sr <= AW'(ir_dst_q);
            dr <= AW'(ir_dst_q);
            i  <= alu_res;
          end else begin
            done <= 1'b1;
          end
        end
        ST_WRITE: begin
          zero  <= alu_zero;
          carry <= alu_carry;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_ctrl.sv
// Bench for reg_ctrl with a behavioural 4x8 register group (power-up 0x01,
// combinational read, falling-edge write). Directed instructions push their
// expected write/done events into a scoreboard; a monitor pops and compares.
module tb_reg_ctrl;

  logic       clk;
  logic       rst;
  logic       instr_valid;
  logic [7:0] instr;
  logic [7:0] imm;
  logic       instr_ready;
  logic [7:0] s, d;
  logic       we;
  logic [1:0] sr, dr;
  logic [7:0] i;
  logic       done, zero, carry;

  reg_ctrl #(.W(8), .AW(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .imm         (imm),
    .instr_ready (instr_ready),
    .s           (s),
    .d           (d),
    .we          (we),
    .sr          (sr),
    .dr          (dr),
    .i           (i),
    .done        (done),
    .zero        (zero),
    .carry       (carry)
  );

  // Register group model
  logic [7:0] regs [4] = '{8'h01, 8'h01, 8'h01, 8'h01};
  assign s = regs[sr];
  assign d = regs[dr];
  always @(negedge clk) if (we) regs[dr] <= i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         kind;   // 0 = write strobe, 1 = done pulse
    logic [1:0] sel;
    logic [7:0] val;
    bit         z;
    bit         c;
    int         cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t me;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Monitor: every we or done pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (sbq.size() == 0) chk("unexpected_we", 1, 0);
      else begin
        me = sbq.pop_front();
        chk("we_kind", 32'(me.kind), 0);
        chk("we_cycle", cyc, me.cyc);
        chk("we_sr", 32'(sr), 32'(me.sel));
        chk("we_dr", 32'(dr), 32'(me.sel));
        chk("we_data", 32'(i), 32'(me.val));
      end
    end
    if (done === 1'b1) begin
      if (sbq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        me = sbq.pop_front();
        chk("done_kind", 32'(me.kind), 1);
        chk("done_cycle", cyc, me.cyc);
        chk("zero", 32'(zero), 32'(me.z));
        chk("carry", 32'(carry), 32'(me.c));
      end
    end
  end

  // Offer one instruction; c0 is the monitor's cycle count of cycle 0
  task automatic send(input logic [7:0] ins, input logic [7:0] im, output int c0);
    int n = 0;
    while (instr_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) chk("ready_timeout", 0, 1);
    instr       = ins;
    imm         = im;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    c0          = cyc - 1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_done();
    int  n    = 0;
    bit  seen = 0;
    while (!seen && n < 12) begin
      @(negedge clk);
      seen = (done === 1'b1);
      n++;
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  // Issue an instruction and queue its expected events
  task automatic run(input logic [7:0] ins, input logic [7:0] im, input bit wr,
                     input logic [7:0] val, input bit z, input bit c);
    int   c0;
    exp_t e;
    send(ins, im, c0);
    e.sel = ins[1:0];
    e.val = val;
    if (wr) begin
      e.kind = 0; e.z = 0; e.c = 0; e.cyc = c0 + 3;
      sbq.push_back(e);
      e.kind = 1; e.z = z; e.c = c; e.cyc = c0 + 4;
      sbq.push_back(e);
    end else begin
      e.kind = 1; e.z = z; e.c = c; e.cyc = c0 + 3;
      sbq.push_back(e);
    end
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   c0;
    exp_t e;
    rst = 1'b1; instr_valid = 1'b0; instr = '0; imm = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_sr", 32'(sr), 0);
    chk("rst_dr", 32'(dr), 0);
    chk("rst_i", 32'(i), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_zero", 32'(zero), 0);
    chk("rst_carry", 32'(carry), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("ready_after_rst", 32'(instr_ready), 1);

    // LDI r2, 0x5A
    run(8'h72, 8'h5A, 1, 8'h5A, 0, 0);
    chk("r2_ldi", 32'(regs[2]), 32'h5A);

    // ADD r0 += r1 : 1 + 1
    run(8'h14, 8'h00, 1, 8'h02, 0, 0);
    chk("r0_add", 32'(regs[0]), 32'h02);
    chk("r1_add", 32'(regs[1]), 32'h01);

    // LDI r3, 0xFF then INC r3 wraps to 0
    run(8'h73, 8'hFF, 1, 8'hFF, 0, 0);
    run(8'h63, 8'h00, 1, 8'h00, 1, 1);
    chk("r3_inc", 32'(regs[3]), 32'h00);

    // LDI r0, 0x00 then SUB r0 -= r1 borrows
    run(8'h70, 8'h00, 1, 8'h00, 1, 0);
    run(8'h24, 8'h00, 1, 8'hFF, 0, 1);
    chk("r0_sub", 32'(regs[0]), 32'hFF);

    // NOP 0xF0 with instr_valid held through the busy cycles
    instr = 8'hF0; imm = 8'h00; instr_valid = 1'b1;
    @(posedge clk); #1;
    c0 = cyc - 1;
    e.kind = 1; e.sel = 2'd0; e.val = 8'h00; e.z = 0; e.c = 1; e.cyc = c0 + 3;
    sbq.push_back(e);
    chk("busy_ready_c1", 32'(instr_ready), 0);
    @(posedge clk); #1;
    chk("busy_ready_c2", 32'(instr_ready), 0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    wait_done();
    chk("nop_zero_kept", 32'(zero), 0);
    chk("nop_carry_kept", 32'(carry), 1);

    // LDI r1, 0x33 with reset asserted during its WRITE cycle
    send(8'h71, 8'h33, c0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rstw_we", 32'(we), 0);
    chk("rstw_ready", 32'(instr_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rstw_r1", 32'(regs[1]), 32'h01);
    chk("rstw_ready_idle", 32'(instr_ready), 1);
    chk("rstw_sr", 32'(sr), 0);
    chk("rstw_dr", 32'(dr), 0);
    chk("rstw_i", 32'(i), 0);
    chk("rstw_done", 32'(done), 0);
    chk("rstw_zero", 32'(zero), 0);
    chk("rstw_carry", 32'(carry), 0);

    // MOV r3 <- r2, NOT r1 <- ~r2
    run(8'h0B, 8'h00, 1, 8'h5A, 0, 0);
    chk("r3_mov", 32'(regs[3]), 32'h5A);
    run(8'h59, 8'h00, 1, 8'hA5, 0, 0);
    chk("r1_not", 32'(regs[1]), 32'hA5);

    // LDI r1, 0x81 then opcode 8 on r1
    run(8'h71, 8'h81, 1, 8'h81, 0, 0);
`ifdef REG_CTRL_SHIFT_EN
    run(8'h85, 8'h00, 1, 8'h02, 0, 1);
    chk("r1_shl", 32'(regs[1]), 32'h02);
`else
    run(8'h85, 8'h00, 0, 8'h00, 0, 0);
    chk("r1_op8_nop", 32'(regs[1]), 32'h81);
`endif

    repeat (3) @(posedge clk);
    #1 chk("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
